// File: rtl/bcd_varredura_if.sv
// Bus between the datapath and the multiplexed display driver.
// The master drives the value and the control strobes; the slave (the driver)
// returns the display pins and its status flags.
interface bcd_varredura_if #(
  parameter int DIGITOS = 4,
  parameter int LARGURA = 16
);
  logic [LARGURA-1:0] valor;
  logic               carregar;
  logic               modo;
  logic               apagar_zeros;
  logic [6:0]         segmentos;
  logic [DIGITOS-1:0] anodos;
  logic               ocupado;
  logic               overflow;

  modport master (
    output valor, carregar, modo, apagar_zeros,
    input  segmentos, anodos, ocupado, overflow
  );

  modport slave (
    input  valor, carregar, modo, apagar_zeros,
    output segmentos, anodos, ocupado, overflow
  );
endinterface

// File: rtl/bcd_varredura.sv
// Time-multiplexed seven-segment driver: sequential shift-add-3 binary to BCD
// conversion, raw BCD pass-through, leading-zero blanking, overflow dashes and
// an independent digit scan with active-low segments and digit enables.
module bcd_varredura #(
  parameter int DIGITOS       = 4,
  parameter int LARGURA       = 16,
  parameter int DIV_VARREDURA = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_varredura_if.slave    bus
);

  localparam int W  = 4 * DIGITOS;
  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int PW = $clog2(DIV_VARREDURA);
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam logic [31:0] LIMITE = 32'(10 ** DIGITOS - 1);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] FIM      = 2'd2;

  // Raw BCD pass-through needs every displayed nibble to exist in valor.
  generate
    if (LARGURA < W) begin : g_largura_invalida
      $error("bcd_varredura: LARGURA must be at least 4*DIGITOS");
    end
  endgenerate

  function automatic logic [6:0] seg_codigo(input logic [3:0] n);
    case (n)
      4'd0:    seg_codigo = 7'b0000001;
      4'd1:    seg_codigo = 7'b1001111;
      4'd2:    seg_codigo = 7'b0010010;
      4'd3:    seg_codigo = 7'b0000110;
      4'd4:    seg_codigo = 7'b1001100;
      4'd5:    seg_codigo = 7'b0100100;
      4'd6:    seg_codigo = 7'b1100000;
      4'd7:    seg_codigo = 7'b0001111;
      4'd8:    seg_codigo = 7'b0000000;
      4'd9:    seg_codigo = 7'b0001100;
      default: seg_codigo = 7'b1111111;
    endcase
  endfunction

  logic [1:0]         estado_q, estado_d;
  logic [LARGURA-1:0] bin_q, bin_d;
  logic [W-1:0]       bcd_q, bcd_d, bcd_ajustado;
  logic [CW-1:0]      cont_q, cont_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic               overflow_q, overflow_d;
  logic               carga_bcd_q, carga_bcd_d;
  logic [W-1:0]       disp_q, disp_d;

  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d, idx_prox;
  logic [6:0]         seg_q, seg_d, seg_novo;
  logic [DIGITOS-1:0] an_q, an_d;
  logic [3:0]         nibble;
  logic               zeros_acima;

  // Converter FSM: load, LARGURA shift-add-3 steps, then publish the result.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    estado_d     = estado_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cont_d       = cont_q;
    ovf_cap_d    = ovf_cap_q;
    overflow_d   = overflow_q;
    carga_bcd_d  = 1'b0;
    disp_d       = disp_q;
    bcd_ajustado = bcd_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_ajustado[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    // A raw BCD value staged in bcd_q reaches the display one edge after the load.
    if (carga_bcd_q) begin
      disp_d     = bcd_q;
      overflow_d = 1'b0;
    end
    case (estado_q)
      OCIOSO: begin
        if (bus.carregar) begin
          if (bus.modo) begin
            bcd_d       = bus.valor[W-1:0];
            carga_bcd_d = 1'b1;
          end else begin
            bin_d     = bus.valor;
            bcd_d     = '0;
            cont_d    = CW'(LARGURA - 1);
            ovf_cap_d = ({{(32-LARGURA){1'b0}}, bus.valor} > LIMITE);
            estado_d  = CONVERTE;
          end
        end
      end
      CONVERTE: begin
        {bcd_d, bin_d} = {bcd_ajustado, bin_q} << 1;
        if (cont_q == '0) estado_d = FIM;
        else              cont_d   = cont_q - CW'(1);
      end
      FIM: begin
        disp_d     = bcd_q;
        overflow_d = ovf_cap_q;
        estado_d   = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Scan: at each prescaler terminal count move to the next digit and reload its pins.
  always_comb begin
    presc_d     = presc_q + PW'(1);
    idx_d       = idx_q;
    seg_d       = seg_q;
    an_d        = an_q;
    idx_prox    = (idx_q == IW'(DIGITOS - 1)) ? '0 : idx_q + IW'(1);
    nibble      = disp_q[4*idx_prox +: 4];
    zeros_acima = ((disp_q >> (4 * idx_prox)) == '0);
    if (overflow_q)                                          seg_novo = 7'b1111110;
    else if (bus.apagar_zeros && idx_prox != '0 && zeros_acima) seg_novo = 7'b1111111;
    else                                                     seg_novo = seg_codigo(nibble);
    if (presc_q == PW'(DIV_VARREDURA - 1)) begin
      presc_d = '0;
      idx_d   = idx_prox;
      an_d    = ~(DIGITOS'(1) << idx_prox);
      seg_d   = seg_novo;
    end
  end

  // State registers; reset blanks the display and disables every digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      bin_q       <= '0;
      bcd_q       <= '0;
      cont_q      <= '0;
      ovf_cap_q   <= 1'b0;
      overflow_q  <= 1'b0;
      carga_bcd_q <= 1'b0;
      disp_q      <= '1;
      presc_q     <= '0;
      idx_q       <= IW'(DIGITOS - 1);
      seg_q       <= 7'b1111111;
      an_q        <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      estado_q    <= estado_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cont_q      <= cont_d;
      ovf_cap_q   <= ovf_cap_d;
      overflow_q  <= overflow_d;
      carga_bcd_q <= carga_bcd_d;
      disp_q      <= disp_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.segmentos = seg_q;
  assign bus.anodos    = an_q;
  assign bus.ocupado   = (estado_q != OCIOSO);
  assign bus.overflow  = overflow_q;

endmodule
